// File: rtl/tictactoe_pkg.sv
// Shared types, winning-line table and board helper functions for the
// TicTacToe game-state controller.
package tictactoe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      X     = 2'b01,
      O     = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      PLAY  = 2'b00,
      CHECK = 2'b01,
      WIN   = 2'b10,
      DRAW  = 2'b11
   } gstate_t;

   localparam int NUM_CELLS = 9;
   localparam int NUM_LINES = 8;

   // Line order matches the win_line bit order: rows, columns, then diagonals.
   localparam logic [3:0] WIN_LINES [0:7][0:2] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   // Extract the two-bit mark stored for one cell.
   function automatic cell_t cell_at(input logic [17:0] b, input logic [3:0] idx);
      return cell_t'(b[{idx, 1'b0} +: 2]);
   endfunction

   // Lowest-index empty cell; returns 0 when the board is full (never used then).
   function automatic logic [3:0] first_empty(input logic [17:0] b);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
         if (cell_at(b, 4'(i)) == EMPTY) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // One bit per line that is completely filled with the given mark.
   function automatic logic [7:0] line_hits(input logic [17:0] b, input cell_t mark);
      logic [7:0] hits;
      hits = 8'd0;
      for (int l = 0; l < NUM_LINES; l++) begin
         hits[l] = (cell_at(b, WIN_LINES[l][0]) == mark) &&
                   (cell_at(b, WIN_LINES[l][1]) == mark) &&
                   (cell_at(b, WIN_LINES[l][2]) == mark);
      end
      return hits;
   endfunction

endpackage

// File: rtl/button_conditioner.sv
// Two-flop synchronizer followed by a rising-edge detector: one clock-wide
// pulse per press, no matter how long the button is held.
module button_conditioner (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic pulse
);

   logic ff1_q;
   logic ff2_q;
   logic ff3_q;

   // Synchronize the raw pin and keep one extra stage for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ff1_q <= 1'b0;
         ff2_q <= 1'b0;
         ff3_q <= 1'b0;
      end else begin
         ff1_q <= btn_in;
         ff2_q <= ff1_q;
         ff3_q <= ff2_q;
      end
   end

   assign pulse = ff2_q & ~ff3_q;

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// TicTacToe game-state controller: conditions the three buttons, owns the
// board, cursor, turn and turn timer, and resolves win/draw. Every output
// comes straight from a register so the renderer sees a glitch-free board.
module tictactoe_game_ctrl
   import tictactoe_pkg::*;
#(
   parameter int unsigned TURN_TICKS = 500_000_000,
   parameter int unsigned TMR_W      = 29
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_next,
   input  logic        btn_place,
   input  logic        btn_new,
   output logic [17:0] board,
   output logic [3:0]  cursor,
   output logic        turn,
   output logic [1:0]  game_state,
   output logic [1:0]  winner,
   output logic [7:0]  win_line,
   output logic [3:0]  move_count
);

   localparam bit               TMR_EN   = (TURN_TICKS != 32'd0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TURN_TICKS - 32'd1);

   logic next_p_s;
   logic place_p_s;
   logic new_p_s;

   button_conditioner u_btn_next (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_next),
      .pulse  (next_p_s)
   );

   button_conditioner u_btn_place (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_place),
      .pulse  (place_p_s)
   );

   button_conditioner u_btn_new (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_new),
      .pulse  (new_p_s)
   );

   gstate_t          state_q,      state_d;
   logic [17:0]      board_q,      board_d;
   logic [3:0]       cursor_q,     cursor_d;
   logic             turn_q,       turn_d;
   logic [1:0]       winner_q,     winner_d;
   logic [7:0]       win_line_q,   win_line_d;
   logic [3:0]       move_count_q, move_count_d;
   logic [TMR_W-1:0] timer_q,      timer_d;

   cell_t            mark_s;
   logic [3:0]       empty_idx_s;
   logic [7:0]       hits_s;
   logic             timeout_s;
   logic             cur_empty_s;
   logic [TMR_W-1:0] timer_inc_s;

   // Helper terms shared by the next-state logic.
   always_comb begin
      mark_s      = turn_q ? O : X;
      empty_idx_s = first_empty(board_q);
      hits_s      = line_hits(board_q, mark_s);
      timeout_s   = TMR_EN && (timer_q == TMR_LAST);
      cur_empty_s = (cell_at(board_q, cursor_q) == EMPTY);
      if (TMR_EN) begin
         timer_inc_s = timer_q + TMR_W'(1);
      end else begin
         timer_inc_s = timer_q;
      end
   end

   // Game FSM: new > place > next, timeout auto-place, one-cycle line check.
   always_comb begin
      state_d      = state_q;
      board_d      = board_q;
      cursor_d     = cursor_q;
      turn_d       = turn_q;
      winner_d     = winner_q;
      win_line_d   = win_line_q;
      move_count_d = move_count_q;
      timer_d      = timer_q;

      if (new_p_s) begin
         state_d      = PLAY;
         board_d      = 18'd0;
         cursor_d     = 4'd4;
         turn_d       = 1'b0;
         winner_d     = 2'b00;
         win_line_d   = 8'd0;
         move_count_d = 4'd0;
         timer_d      = '0;
      end else begin
         case (state_q)
            PLAY: begin
               if (place_p_s) begin
                  if (cur_empty_s) begin
                     board_d[{cursor_q, 1'b0} +: 2] = mark_s;
                     move_count_d = move_count_q + 4'd1;
                     state_d      = CHECK;
                  end else if (timeout_s) begin
                     // The ignored press still consumed the timeout; restart the turn period.
                     timer_d = '0;
                  end else begin
                     timer_d = timer_inc_s;
                  end
               end else if (timeout_s) begin
                  board_d[{empty_idx_s, 1'b0} +: 2] = mark_s;
                  cursor_d     = empty_idx_s;
                  move_count_d = move_count_q + 4'd1;
                  state_d      = CHECK;
               end else begin
                  if (next_p_s) begin
                     cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
                  end else begin
                     cursor_d = cursor_q;
                  end
                  timer_d = timer_inc_s;
               end
            end
            CHECK: begin
               win_line_d = hits_s;
               if (|hits_s) begin
                  state_d  = WIN;
                  winner_d = mark_s;
               end else if (move_count_q == 4'd9) begin
                  state_d = DRAW;
               end else begin
                  turn_d  = ~turn_q;
                  timer_d = '0;
                  state_d = PLAY;
               end
            end
            WIN: begin
               state_d = WIN;
            end
            DRAW: begin
               state_d = DRAW;
            end
            default: begin
               state_d = PLAY;
            end
         endcase
      end
   end

   // Game state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= PLAY;
         board_q      <= 18'd0;
         cursor_q     <= 4'd4;
         turn_q       <= 1'b0;
         winner_q     <= 2'b00;
         win_line_q   <= 8'd0;
         move_count_q <= 4'd0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         board_q      <= board_d;
         cursor_q     <= cursor_d;
         turn_q       <= turn_d;
         winner_q     <= winner_d;
         win_line_q   <= win_line_d;
         move_count_q <= move_count_d;
         timer_q      <= timer_d;
      end
   end

   assign board      = board_q;
   assign cursor     = cursor_q;
   assign turn       = turn_q;
   assign game_state = state_q;
   assign winner     = winner_q;
   assign win_line   = win_line_q;
   assign move_count = move_count_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Bench for tictactoe_game_ctrl: two instances share the button pins, one
// with the turn timer disabled and one with a 16-cycle turn. A game-level
// model tracks both and is compared every cycle; literal checks pin the model.
module tb_tictactoe_game_ctrl;

   logic clk;
   logic rst;
   logic btn_next;
   logic btn_place;
   logic btn_new;

   logic [17:0] board_w      [2];
   logic [3:0]  cursor_w     [2];
   logic        turn_w       [2];
   logic [1:0]  state_w      [2];
   logic [1:0]  winner_w     [2];
   logic [7:0]  win_line_w   [2];
   logic [3:0]  move_count_w [2];

   tictactoe_game_ctrl #(.TURN_TICKS(0), .TMR_W(5)) u_dut0 (
      .clk(clk), .rst(rst), .btn_next(btn_next), .btn_place(btn_place), .btn_new(btn_new),
      .board(board_w[0]), .cursor(cursor_w[0]), .turn(turn_w[0]), .game_state(state_w[0]),
      .winner(winner_w[0]), .win_line(win_line_w[0]), .move_count(move_count_w[0])
   );

   tictactoe_game_ctrl #(.TURN_TICKS(16), .TMR_W(5)) u_dut1 (
      .clk(clk), .rst(rst), .btn_next(btn_next), .btn_place(btn_place), .btn_new(btn_new),
      .board(board_w[1]), .cursor(cursor_w[1]), .turn(turn_w[1]), .game_state(state_w[1]),
      .winner(winner_w[1]), .win_line(win_line_w[1]), .move_count(move_count_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Cells hold 0 empty, 1 X, 2 O; state 0 PLAY, 1 CHECK, 2 WIN, 3 DRAW.
   int tt [2] = '{0, 16};
   int m_b    [2][9];
   int m_cur  [2];
   int m_turn [2];
   int m_st   [2];
   int m_win  [2];
   int m_wl   [2];
   int m_mc   [2];
   int m_tmr  [2];
   int lines  [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   // Recent pin samples, newest first: a press acts two edges after it is first seen.
   bit [2:0] h_next, h_place, h_new;

   task automatic m_new_game(input int k);
      for (int i = 0; i < 9; i++) m_b[k][i] = 0;
      m_cur[k] = 4; m_turn[k] = 0; m_st[k] = 0; m_win[k] = 0;
      m_wl[k] = 0;  m_mc[k] = 0;   m_tmr[k] = 0;
   endtask

   task automatic m_step(input int k, input bit pn, input bit pp, input bit pw);
      bit to;
      int f;
      int mark;
      if (pw) begin
         m_new_game(k);
      end else if (m_st[k] == 0) begin
         to = (tt[k] != 0) && (m_tmr[k] == tt[k] - 1);
         if (pp) begin
            if (m_b[k][m_cur[k]] == 0) begin
               m_b[k][m_cur[k]] = m_turn[k] + 1;
               m_mc[k]++;
               m_st[k] = 1;
            end else begin
               m_tmr[k] = to ? 0 : m_tmr[k] + 1;
            end
         end else if (to) begin
            f = -1;
            for (int i = 8; i >= 0; i--) if (m_b[k][i] == 0) f = i;
            m_b[k][f] = m_turn[k] + 1;
            m_cur[k] = f;
            m_mc[k]++;
            m_st[k] = 1;
         end else begin
            if (pn) m_cur[k] = (m_cur[k] + 1) % 9;
            m_tmr[k]++;
         end
      end else if (m_st[k] == 1) begin
         mark = m_turn[k] + 1;
         m_wl[k] = 0;
         for (int l = 0; l < 8; l++)
            if (m_b[k][lines[l][0]] == mark && m_b[k][lines[l][1]] == mark &&
                m_b[k][lines[l][2]] == mark) m_wl[k] |= (1 << l);
         if (m_wl[k] != 0) begin
            m_st[k] = 2;
            m_win[k] = mark;
         end else if (m_mc[k] == 9) begin
            m_st[k] = 3;
         end else begin
            m_turn[k] ^= 1;
            m_tmr[k] = 0;
            m_st[k] = 0;
         end
      end
   endtask

   initial begin
      bit pn, pp, pw;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            h_next = 3'b000; h_place = 3'b000; h_new = 3'b000;
            for (int k = 0; k < 2; k++) m_new_game(k);
         end else begin
            pn = h_next[1]  & ~h_next[2];
            pp = h_place[1] & ~h_place[2];
            pw = h_new[1]   & ~h_new[2];
            h_next  = {h_next[1:0],  btn_next};
            h_place = {h_place[1:0], btn_place};
            h_new   = {h_new[1:0],   btn_new};
            for (int k = 0; k < 2; k++) m_step(k, pn, pp, pw);
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   initial begin
      logic [17:0] pb;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
               pb = 18'd0;
               for (int i = 0; i < 9; i++) pb[2*i +: 2] = 2'(m_b[k][i]);
               check($sformatf("model_board%0d", k),    32'(board_w[k]),      32'(pb));
               check($sformatf("model_cursor%0d", k),   32'(cursor_w[k]),     32'(m_cur[k]));
               check($sformatf("model_turn%0d", k),     32'(turn_w[k]),       32'(m_turn[k]));
               check($sformatf("model_state%0d", k),    32'(state_w[k]),      32'(m_st[k]));
               check($sformatf("model_winner%0d", k),   32'(winner_w[k]),     32'(m_win[k]));
               check($sformatf("model_winline%0d", k),  32'(win_line_w[k]),   32'(m_wl[k]));
               check($sformatf("model_movecnt%0d", k),  32'(move_count_w[k]), 32'(m_mc[k]));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit n, input bit p, input bit w);
      @(negedge clk); #1;
      btn_next = n; btn_place = p; btn_new = w;
      @(negedge clk); #1;
      btn_next = 1'b0; btn_place = 1'b0; btn_new = 1'b0;
   endtask

   // Walk the timer-less instance's cursor to a target cell.
   task automatic goto_cell(input int tgt);
      int cnt;
      idle(3);
      cnt = (tgt - m_cur[0] + 9) % 9;
      repeat (cnt) press(1'b1, 1'b0, 1'b0);
      idle(3);
   endtask

   task automatic place_at(input int tgt);
      goto_cell(tgt);
      press(1'b0, 1'b1, 1'b0);
      idle(3);
   endtask

   task automatic check_reset_vals(input string tag, input int k);
      check({tag, "_board"},   32'(board_w[k]),      32'h0);
      check({tag, "_cursor"},  32'(cursor_w[k]),     32'h4);
      check({tag, "_turn"},    32'(turn_w[k]),       32'h0);
      check({tag, "_state"},   32'(state_w[k]),      32'h0);
      check({tag, "_winner"},  32'(winner_w[k]),     32'h0);
      check({tag, "_winline"}, 32'(win_line_w[k]),   32'h0);
      check({tag, "_movecnt"}, 32'(move_count_w[k]), 32'h0);
   endtask

   initial begin
      int x0, y0;
      rst = 1'b0; btn_next = 1'b0; btn_place = 1'b0; btn_new = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);
      check_reset_vals("rst0", 0);
      check_reset_vals("rst1", 1);

      // Turn timeout: X at 0, then O auto-placed at cell 1 on the timed instance.
      press(1'b0, 1'b0, 1'b1);
      place_at(0);
      idle(20);
      check("t5_board1",  32'(board_w[1]),      32'h9);
      check("t5_cursor1", 32'(cursor_w[1]),     32'h1);
      check("t5_turn1",   32'(turn_w[1]),       32'h0);
      check("t5_mc1",     32'(move_count_w[1]), 32'h2);
      check("t5_board0",  32'(board_w[0]),      32'h1);
      check("t5_turn0",   32'(turn_w[0]),       32'h1);

      // Cursor wrap and placing onto an occupied cell.
      press(1'b0, 1'b0, 1'b1);
      place_at(4);
      press(1'b0, 1'b1, 1'b0);
      idle(3);
      check("t4_board",   32'(board_w[0]),      32'h100);
      check("t4_turn",    32'(turn_w[0]),       32'h1);
      check("t4_mc",      32'(move_count_w[0]), 32'h1);
      goto_cell(8);
      check("t4_cur8",    32'(cursor_w[0]),     32'h8);
      press(1'b1, 1'b0, 1'b0);
      idle(3);
      check("t4_wrap",    32'(cursor_w[0]),     32'h0);

      // Reset mid-game, then a full row-0 win for X.
      press(1'b0, 1'b0, 1'b1);
      place_at(0);
      place_at(3);
      @(negedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_reset_vals("t1_mid0", 0);
      check_reset_vals("t1_mid1", 1);
      #1 rst = 1'b1;
      place_at(0);
      place_at(3);
      place_at(1);
      place_at(4);
      place_at(2);
      check("t2_state",   32'(state_w[0]),      32'h2);
      check("t2_winner",  32'(winner_w[0]),     32'h1);
      check("t2_winline", 32'(win_line_w[0]),   32'h01);
      check("t2_board",   32'(board_w[0]),      32'h295);
      check("t2_mc",      32'(move_count_w[0]), 32'h5);
      x0 = cursor_w[0];
      press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      idle(4);
      check("t2_hold_board", 32'(board_w[0]),  32'h295);
      check("t2_hold_cur",   32'(cursor_w[0]), 32'(x0));
      check("t2_hold_state", 32'(state_w[0]),  32'h2);

      // Draw.
      press(1'b0, 1'b0, 1'b1);
      foreach (lines[0][i]) y0 = i;
      place_at(4); place_at(0); place_at(2); place_at(6); place_at(3);
      place_at(5); place_at(1); place_at(7); place_at(8);
      check("t3_state",  32'(state_w[0]),      32'h3);
      check("t3_mc",     32'(move_count_w[0]), 32'h9);
      check("t3_winner", 32'(winner_w[0]),     32'h0);
      check("t3_board",  32'(board_w[0]),      32'h1A956);

      // Same-cycle place+new, then held buttons.
      press(1'b0, 1'b0, 1'b1);
      goto_cell(6);
      press(1'b0, 1'b1, 1'b1);
      idle(3);
      check("t6_board",  32'(board_w[0]),  32'h0);
      check("t6_cursor", 32'(cursor_w[0]), 32'h4);
      check("t6_state",  32'(state_w[0]),  32'h0);
      @(negedge clk); #1 btn_next = 1'b1;
      idle(100);
      #1 btn_next = 1'b0;
      idle(3);
      check("t6_held_next", 32'(cursor_w[0]), 32'h5);
      @(negedge clk); #1 btn_place = 1'b1;
      idle(100);
      #1 btn_place = 1'b0;
      idle(3);
      check("t6_held_board", 32'(board_w[0]),      32'h400);
      check("t6_held_mc",    32'(move_count_w[0]), 32'h1);

      // Random play against the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); #1;
         btn_next  = ($urandom_range(0, 2) == 0);
         btn_place = ($urandom_range(0, 3) == 0);
         btn_new   = ($urandom_range(0, 59) == 0);
         rst       = ($urandom_range(0, 799) != 0);
      end
      @(negedge clk); #1;
      btn_next = 1'b0; btn_place = 1'b0; btn_new = 1'b0; rst = 1'b1;
      idle(6);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
